// File: rtl/fifo_rd_stream.sv
// Purpose: turns a 1-cycle-latency FIFO read port into a framed valid/ready stream with a 4-entry prefetch buffer.
// Latency: read issued in T, word on the FIFO bus in T+1, presented on out_valid_o in T+2.
// Backpressure: reads stop once buffered + in-flight words reach 4; out_ready_i never drives the read request.
// Optional flush input is enabled by defining FIFO_RD_STREAM_FLUSH_EN.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef FIFO_RD_STREAM_FLUSH_EN
    input  logic                  flush_i,
`endif
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_rd_empty_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  idle_o
);

    localparam int BW = $clog2(PKT_LEN) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic [2:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [BW-1:0]         beat_q, beat_d;
    logic [DATA_WIDTH-1:0] buf_q [4];
    logic [DATA_WIDTH-1:0] hold_q;

    logic                  flush;
    logic                  capture;
    logic                  hs;

`ifdef FIFO_RD_STREAM_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Read request: only from registered state and the FIFO empty flag, so the
    // consumer's ready never reaches the FIFO in the same cycle.
    always_comb begin
        fifo_rd_en_o = !rst_i && !flush && !fifo_rd_empty_i &&
                       (({1'b0, occ_q} + {3'b0, inflight_q}) < 4'(BUF_DEPTH));
    end

    // Stream side: head of the buffer, handshake, and next occupancy/beat values.
    always_comb begin
        capture     = inflight_q;
        out_valid_o = (occ_q != 3'd0);
        hs          = out_valid_o && out_ready_i;
        out_data_o  = out_valid_o ? buf_q[rd_ptr_q] : hold_q;
        out_last_o  = out_valid_o && (beat_q == LAST_BEAT);
        idle_o      = (occ_q == 3'd0) && !inflight_q;
        occ_d       = occ_q + {2'b0, capture} - {2'b0, hs};
        beat_d      = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end

    // Control state: occupancy, in-flight tracking, pointers, beat counter and
    // the held head value shown while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            hold_q     <= '0;
        end else if (flush) begin
            // The word returning this cycle belongs to the discarded stream.
            occ_q      <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
        end else begin
            inflight_q <= fifo_rd_en_o;
            occ_q      <= occ_d;
            if (capture) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (hs) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
                beat_q   <= beat_d;
            end
            if (out_valid_o) begin
                hold_q <= buf_q[rd_ptr_q];
            end
        end
    end

    // Prefetch storage: the slot at wr_ptr is never the live head while a
    // capture is possible, because occ is at most 3 whenever a read is in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush && capture) begin
            buf_q[wr_ptr_q] <= fifo_rd_data_i;
        end
    end

endmodule
